number_entry: RTL and testbench
===============================

Name: number_entry

Overview:
- Decimal keypad-entry accumulator. Collects up to DIGITS decimal key codes and converts them to a 13-bit binary value.
- Drives number_in of the 3-digit on-screen number overlay, i.e. it writes the value that the overlay renders.
- Sits between the keypad/UART key decoder and the VGA overlay chain; runs in the pixel clock domain.

Parameters:
DIGITS, 3, maximum digits per entry; legal 1..3, so the max value 999 fits 13 bits.
TIMEOUT, 40_000_000, clock cycles of key inactivity in ENTRY before the entry is aborted; 0 disables the timeout.

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle strobe: key_code is valid
key_code  input  4  0-9 digit, 0xA enter, 0xB clear, 0xC backspace (see Optional Feature), others ignored
number_out  output  13  last committed binary value, to overlay number_in
edit_out  output  13  binary value of digits entered so far
digit_count  output  2  number of digits currently held
busy  output  1  high while state is ENTRY or COMMIT
commit_pulse  output  1  one-cycle pulse: number_out just updated
err_pulse  output  1  one-cycle pulse: key rejected

Behaviour:
- Reset (async, rst=1): state IDLE; digit regs d2,d1,d0=0; digit_count=0; number_out=0; edit_out=0; commit_pulse=0; err_pulse=0; timeout counter=0. Reset mid-entry discards the entry.
- Decode: binary value = d2*100 + d1*10 + d0; multiplies by shift-add; 13-bit unsigned result.
- States:
  - IDLE: digit_count=0.
  - ENTRY: 1..DIGITS digits held.
  - COMMIT: one-cycle lockout after a commit.
- Key acceptance: a key is sampled on a rising edge with key_valid=1 in IDLE or ENTRY. In COMMIT, key_valid is ignored and no err_pulse is raised.
- Digit key, digit_count<DIGITS:
  - shift left (d2<=d1, d1<=d0, d0<=key); digit_count+1; state ENTRY.
  - A leading 0 is accepted and counted.
- Digit key, digit_count==DIGITS: digit dropped; err_pulse=1 next cycle; state unchanged.
- Enter key:
  - In ENTRY: number_out <= decoded value of the current digit regs (same edge; valid even if a digit was accepted the previous cycle); commit_pulse=1 for the next cycle; digits and count cleared; state COMMIT, then IDLE after 1 cycle.
  - In IDLE: err_pulse=1; number_out unchanged.
- Clear key: digits and count cleared; state IDLE; number_out unchanged; no error.
- Ignored codes: no state change; no error.
- Latency:
  - edit_out is registered from the digit regs, so it updates 2 edges after the key edge.
  - number_out and commit_pulse update 1 edge after the enter edge.
- Timeout (TIMEOUT>0):
  - Counter runs only in ENTRY; any accepted key zeroes it.
  - When it reaches TIMEOUT-1: digits cleared, state IDLE, err_pulse=1, number_out unchanged.
  - A key arriving on the expiry edge takes priority, and the counter restarts.
- busy=1 in ENTRY and COMMIT.
- Pulses never overlap: an enter from ENTRY cannot err.

Optional Feature:
- Macro NUMBER_ENTRY_BACKSPACE_EN.
- Defined: code 0xC in ENTRY shifts right (d0<=d1, d1<=d2, d2<=0), digit_count-1, timeout counter zeroed. If the count reaches 0, state returns to IDLE. 0xC in IDLE raises err_pulse.
- Undefined: 0xC is treated as an ignored code; no shift-right logic is synthesised.

Test Plan:
- Keys 4,0,7,enter (each key_valid for 1 cycle, 2 idle cycles apart) -> number_out=407, one commit_pulse, busy low 2 cycles after enter, edit_out=0.
- Keys 1,2,3,9 then enter -> the 9 raises err_pulse; number_out=123.
- Enter in IDLE after reset -> err_pulse=1, number_out=0. Then 5, clear, enter -> number_out stays 0, err_pulse on the final enter.
- Digit 8 on cycle N, enter on cycle N+1 -> number_out=8 at N+2; key_valid during the COMMIT cycle is ignored.
- TIMEOUT=16: key 6, then no keys -> after 16 cycles state IDLE, err_pulse, number_out unchanged. Repeat with a key every 10 cycles -> no timeout.
- With NUMBER_ENTRY_BACKSPACE_EN: 9,1,backspace,2,enter -> number_out=92. Async rst asserted mid-entry -> all outputs 0 immediately.

Source files
------------

// File: rtl/number_entry_if.sv
// Keypad-to-overlay bundle for number_entry: key strobe in, committed/edit values and status out.
interface number_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [12:0] number_out;
  logic [12:0] edit_out;
  logic [1:0]  digit_count;
  logic        busy;
  logic        commit_pulse;
  logic        err_pulse;

  modport master (
    output key_valid, key_code,
    input  number_out, edit_out, digit_count, busy, commit_pulse, err_pulse
  );

  modport slave (
    input  key_valid, key_code,
    output number_out, edit_out, digit_count, busy, commit_pulse, err_pulse
  );
endinterface

// File: rtl/number_entry.sv
// Decimal keypad accumulator: collects up to DIGITS key digits and commits their binary value.
// Define NUMBER_ENTRY_BACKSPACE_EN to enable the backspace key (code 0xC).
module number_entry #(
  parameter int DIGITS  = 3,
  parameter int TIMEOUT = 40_000_000
) (
  input logic           clk,
  input logic           rst,
  number_entry_if.slave ne
);

  typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_COMMIT} state_e;

  localparam int             CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]     MAX_CNT   = 2'(DIGITS);
  localparam logic [CW-1:0]  TO_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]     KEY_ENTER = 4'hA;
  localparam logic [3:0]     KEY_CLEAR = 4'hB;
`ifdef NUMBER_ENTRY_BACKSPACE_EN
  localparam logic [3:0]     KEY_BACK  = 4'hC;
`endif

  state_e          state_q, state_d;
  logic [3:0]      d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [12:0]     num_q, num_d;
  logic [12:0]     edit_q;
  logic            commit_q, commit_d;
  logic            err_q, err_d;
  logic [CW-1:0]   tmr_q, tmr_d;
  logic            key_hit;

  // d2*100 + d1*10 + d0 using shifts and adds only
  function automatic logic [12:0] decode(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    logic [12:0] hh, tt, uu;
    hh = {9'd0, h};
    tt = {9'd0, t};
    uu = {9'd0, u};
    return (hh << 6) + (hh << 5) + (hh << 2) + (tt << 3) + (tt << 1) + uu;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      d2_q     <= '0;
      d1_q     <= '0;
      d0_q     <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      edit_q   <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      d2_q     <= d2_d;
      d1_q     <= d1_d;
      d0_q     <= d0_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      edit_q   <= decode(d2_q, d1_q, d0_q);
      commit_q <= commit_d;
      err_q    <= err_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    d2_d     = d2_q;
    d1_d     = d1_q;
    d0_d     = d0_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    tmr_d    = '0;
    key_hit  = 1'b0;

    // COMMIT is a one-cycle lockout: keys are neither taken nor flagged
    if (state_q == ST_COMMIT) begin
      state_d = ST_IDLE;
    end else begin
      if (ne.key_valid) begin
        if (ne.key_code <= 4'd9) begin
          key_hit = 1'b1;
          if (cnt_q < MAX_CNT) begin
            d2_d    = d1_q;
            d1_d    = d0_q;
            d0_d    = ne.key_code;
            cnt_d   = cnt_q + 2'd1;
            state_d = ST_ENTRY;
          end else begin
            err_d = 1'b1;
          end
        end else if (ne.key_code == KEY_ENTER) begin
          key_hit = 1'b1;
          if (state_q == ST_ENTRY) begin
            num_d    = decode(d2_q, d1_q, d0_q);
            commit_d = 1'b1;
            d2_d     = '0;
            d1_d     = '0;
            d0_d     = '0;
            cnt_d    = '0;
            state_d  = ST_COMMIT;
          end else begin
            err_d = 1'b1;
          end
        end else if (ne.key_code == KEY_CLEAR) begin
          key_hit = 1'b1;
          d2_d    = '0;
          d1_d    = '0;
          d0_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
`ifdef NUMBER_ENTRY_BACKSPACE_EN
        else if (ne.key_code == KEY_BACK) begin
          key_hit = 1'b1;
          if (state_q == ST_ENTRY) begin
            d0_d  = d1_q;
            d1_d  = d2_q;
            d2_d  = '0;
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = ST_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
      end

      // A key on the expiry edge wins and restarts the inactivity count
      if (!key_hit && state_q == ST_ENTRY && TIMEOUT != 0) begin
        if (tmr_q == TO_LAST) begin
          d2_d    = '0;
          d1_d    = '0;
          d0_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end
    end
  end

  assign ne.number_out   = num_q;
  assign ne.edit_out     = edit_q;
  assign ne.digit_count  = cnt_q;
  assign ne.busy         = (state_q != ST_IDLE);
  assign ne.commit_pulse = commit_q;
  assign ne.err_pulse    = err_q;

endmodule

// File: tb/tb_number_entry.sv
// Directed bench for number_entry (DIGITS=3, TIMEOUT=16); backspace cases build only with NUMBER_ENTRY_BACKSPACE_EN.
module tb_number_entry;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  number_entry_if ne_if();

  number_entry #(.DIGITS(3), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .ne  (ne_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key is sampled on the posedge between the two negedges; returns just after that edge
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    ne_if.key_valid = 1'b1;
    ne_if.key_code  = code;
    @(negedge clk);
    ne_if.key_valid = 1'b0;
    $display("key 0x%h  number_out=%0d edit_out=%0d count=%0d busy=%0b commit=%0b err=%0b",
             code, ne_if.number_out, ne_if.edit_out, ne_if.digit_count,
             ne_if.busy, ne_if.commit_pulse, ne_if.err_pulse);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ne_if.key_valid = 1'b0;
    ne_if.key_code  = 4'h0;
    @(negedge clk);
    total++; if (ne_if.number_out !== 13'd0) $display("FAIL reset_number got %0d expected 0", ne_if.number_out); else passed++;
    total++; if (ne_if.edit_out !== 13'd0) $display("FAIL reset_edit got %0d expected 0", ne_if.edit_out); else passed++;
    total++; if (ne_if.busy !== 1'b0 || ne_if.digit_count !== 2'd0) $display("FAIL reset_busy_count got %0b/%0d expected 0/0", ne_if.busy, ne_if.digit_count); else passed++;
    total++; if (ne_if.commit_pulse !== 1'b0 || ne_if.err_pulse !== 1'b0) $display("FAIL reset_pulses got %0b/%0b expected 0/0", ne_if.commit_pulse, ne_if.err_pulse); else passed++;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_idle_enter();
    press(4'hA);
    total++; if (ne_if.err_pulse !== 1'b1) $display("FAIL idle_enter_err got %0b expected 1", ne_if.err_pulse); else passed++;
    total++; if (ne_if.number_out !== 13'd0 || ne_if.commit_pulse !== 1'b0) $display("FAIL idle_enter_number got %0d/%0b expected 0/0", ne_if.number_out, ne_if.commit_pulse); else passed++;
    idle(1);
    press(4'd5);
    total++; if (ne_if.digit_count !== 2'd1 || ne_if.busy !== 1'b1) $display("FAIL digit5_count got %0d/%0b expected 1/1", ne_if.digit_count, ne_if.busy); else passed++;
    press(4'hB);
    total++; if (ne_if.digit_count !== 2'd0 || ne_if.busy !== 1'b0 || ne_if.err_pulse !== 1'b0) $display("FAIL clear got %0d/%0b/%0b expected 0/0/0", ne_if.digit_count, ne_if.busy, ne_if.err_pulse); else passed++;
    press(4'hA);
    total++; if (ne_if.err_pulse !== 1'b1 || ne_if.number_out !== 13'd0) $display("FAIL enter_after_clear got err=%0b num=%0d expected 1/0", ne_if.err_pulse, ne_if.number_out); else passed++;
    idle(1);
  endtask

  task automatic test_basic_entry();
    press(4'd4); idle(2);
    press(4'd0); idle(2);
    press(4'd7); idle(2);
    total++; if (ne_if.edit_out !== 13'd407) $display("FAIL edit_407 got %0d expected 407", ne_if.edit_out); else passed++;
    total++; if (ne_if.digit_count !== 2'd3 || ne_if.busy !== 1'b1) $display("FAIL entry_count got %0d/%0b expected 3/1", ne_if.digit_count, ne_if.busy); else passed++;
    press(4'hA);
    total++; if (ne_if.number_out !== 13'd407) $display("FAIL commit_407 got %0d expected 407", ne_if.number_out); else passed++;
    total++; if (ne_if.commit_pulse !== 1'b1 || ne_if.err_pulse !== 1'b0 || ne_if.busy !== 1'b1) $display("FAIL commit_flags got c=%0b e=%0b b=%0b expected 1/0/1", ne_if.commit_pulse, ne_if.err_pulse, ne_if.busy); else passed++;
    idle(1);
    total++; if (ne_if.commit_pulse !== 1'b0 || ne_if.busy !== 1'b0) $display("FAIL after_commit got c=%0b b=%0b expected 0/0", ne_if.commit_pulse, ne_if.busy); else passed++;
    total++; if (ne_if.edit_out !== 13'd0 || ne_if.digit_count !== 2'd0) $display("FAIL after_commit_edit got %0d/%0d expected 0/0", ne_if.edit_out, ne_if.digit_count); else passed++;
  endtask

  task automatic test_overflow();
    press(4'd1); press(4'd2); press(4'd3);
    press(4'd9);
    total++; if (ne_if.err_pulse !== 1'b1 || ne_if.digit_count !== 2'd3) $display("FAIL overflow_err got %0b/%0d expected 1/3", ne_if.err_pulse, ne_if.digit_count); else passed++;
    idle(1);
    total++; if (ne_if.err_pulse !== 1'b0 || ne_if.edit_out !== 13'd123) $display("FAIL overflow_edit got %0b/%0d expected 0/123", ne_if.err_pulse, ne_if.edit_out); else passed++;
    press(4'hA);
    total++; if (ne_if.number_out !== 13'd123 || ne_if.commit_pulse !== 1'b1) $display("FAIL commit_123 got %0d/%0b expected 123/1", ne_if.number_out, ne_if.commit_pulse); else passed++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ne_if.key_valid = 1'b1; ne_if.key_code = 4'd8;
    @(negedge clk);
    ne_if.key_code = 4'hA;
    @(negedge clk);
    ne_if.key_code = 4'd5;
    $display("key 0x8,0xA,0x5 back-to-back  number_out=%0d commit=%0b", ne_if.number_out, ne_if.commit_pulse);
    total++; if (ne_if.number_out !== 13'd8 || ne_if.commit_pulse !== 1'b1) $display("FAIL b2b_commit got %0d/%0b expected 8/1", ne_if.number_out, ne_if.commit_pulse); else passed++;
    @(negedge clk);
    ne_if.key_valid = 1'b0;
    total++; if (ne_if.digit_count !== 2'd0 || ne_if.busy !== 1'b0 || ne_if.err_pulse !== 1'b0) $display("FAIL commit_lockout got %0d/%0b/%0b expected 0/0/0", ne_if.digit_count, ne_if.busy, ne_if.err_pulse); else passed++;
    total++; if (ne_if.number_out !== 13'd8 || ne_if.commit_pulse !== 1'b0) $display("FAIL b2b_hold got %0d/%0b expected 8/0", ne_if.number_out, ne_if.commit_pulse); else passed++;
  endtask

  task automatic test_timeout();
    press(4'd6);
    idle(15);
    total++; if (ne_if.busy !== 1'b1 || ne_if.err_pulse !== 1'b0) $display("FAIL pre_timeout got b=%0b e=%0b expected 1/0", ne_if.busy, ne_if.err_pulse); else passed++;
    idle(1);
    total++; if (ne_if.busy !== 1'b0 || ne_if.err_pulse !== 1'b1 || ne_if.digit_count !== 2'd0) $display("FAIL timeout got b=%0b e=%0b n=%0d expected 0/1/0", ne_if.busy, ne_if.err_pulse, ne_if.digit_count); else passed++;
    total++; if (ne_if.number_out !== 13'd8) $display("FAIL timeout_number got %0d expected 8", ne_if.number_out); else passed++;
    idle(1);
    press(4'd3); idle(9);
    press(4'd2); idle(9);
    press(4'd1); idle(9);
    total++; if (ne_if.busy !== 1'b1 || ne_if.err_pulse !== 1'b0 || ne_if.digit_count !== 2'd3) $display("FAIL keepalive got b=%0b e=%0b n=%0d expected 1/0/3", ne_if.busy, ne_if.err_pulse, ne_if.digit_count); else passed++;
    total++; if (ne_if.edit_out !== 13'd321) $display("FAIL keepalive_edit got %0d expected 321", ne_if.edit_out); else passed++;
    press(4'hB);
    idle(1);
  endtask

`ifdef NUMBER_ENTRY_BACKSPACE_EN
  task automatic test_backspace();
    press(4'hC);
    total++; if (ne_if.err_pulse !== 1'b1) $display("FAIL idle_backspace got %0b expected 1", ne_if.err_pulse); else passed++;
    press(4'd9); press(4'd1);
    press(4'hC);
    total++; if (ne_if.digit_count !== 2'd1 || ne_if.busy !== 1'b1) $display("FAIL backspace_count got %0d/%0b expected 1/1", ne_if.digit_count, ne_if.busy); else passed++;
    press(4'd2);
    press(4'hA);
    total++; if (ne_if.number_out !== 13'd92) $display("FAIL backspace_commit got %0d expected 92", ne_if.number_out); else passed++;
    idle(2);
  endtask
`endif

  task automatic test_async_reset();
    press(4'd2);
    press(4'hA);
    idle(1);
    total++; if (ne_if.number_out !== 13'd2) $display("FAIL pre_reset_number got %0d expected 2", ne_if.number_out); else passed++;
    press(4'd5); press(4'd5); idle(1);
    #2 rst = 1'b1;
    #1;
    $display("async reset asserted mid-entry  number_out=%0d edit_out=%0d", ne_if.number_out, ne_if.edit_out);
    total++; if (ne_if.number_out !== 13'd0 || ne_if.edit_out !== 13'd0) $display("FAIL async_reset_values got %0d/%0d expected 0/0", ne_if.number_out, ne_if.edit_out); else passed++;
    total++; if (ne_if.digit_count !== 2'd0 || ne_if.busy !== 1'b0) $display("FAIL async_reset_state got %0d/%0b expected 0/0", ne_if.digit_count, ne_if.busy); else passed++;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_idle_enter();
    test_basic_entry();
    test_overflow();
    test_back_to_back();
    test_timeout();
`ifdef NUMBER_ENTRY_BACKSPACE_EN
    test_backspace();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
